// File: rtl/sync_debounce_edge.sv
// Glitch filter and edge detector for an already-synchronized level in the clkB domain.
// A new level is accepted after FILTER_CYCLES equal samples; rises are counted with saturation.
module sync_debounce_edge #(
   parameter int FILTER_CYCLES = 4,
   parameter int EVT_CNT_WIDTH = 8
) (
   input  logic                     clkB,
   input  logic                     rstN,
   input  logic                     en,
   input  logic                     din_sync,
   input  logic                     clr_cnt,
   output logic                     level,
   output logic                     rise,
   output logic                     fall,
   output logic                     busy,
   output logic [EVT_CNT_WIDTH-1:0] rise_count
);

   localparam int QW = $clog2(FILTER_CYCLES + 1);
   localparam logic [QW-1:0] QLAST = QW'(FILTER_CYCLES - 1);
   localparam logic [EVT_CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_QUAL_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_QUAL_LOW  = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [QW-1:0]              qcnt_q, qcnt_d;
   logic                       level_q, level_d;
   logic                       rise_q, rise_d;
   logic                       fall_q, fall_d;
   logic                       busy_q, busy_d;
   logic [EVT_CNT_WIDTH-1:0]   cnt_q, cnt_d;

   // Next-state, qualification counter and next registered outputs
   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (en && din_sync) begin
               if (FILTER_CYCLES == 1) begin
                  state_d = S_HIGH;
                  rise_d  = 1'b1;
               end else begin
                  state_d = S_QUAL_HIGH;
                  qcnt_d  = QW'(1);
               end
            end else begin
               state_d = S_LOW;
            end
         end
         S_QUAL_HIGH: begin
            if (!en || !din_sync) begin
               state_d = S_LOW;
               qcnt_d  = '0;
            end else if (qcnt_q == QLAST) begin
               state_d = S_HIGH;
               qcnt_d  = '0;
               rise_d  = 1'b1;
            end else begin
               qcnt_d  = qcnt_q + QW'(1);
            end
         end
         S_HIGH: begin
            if (en && !din_sync) begin
               if (FILTER_CYCLES == 1) begin
                  state_d = S_LOW;
                  fall_d  = 1'b1;
               end else begin
                  state_d = S_QUAL_LOW;
                  qcnt_d  = QW'(1);
               end
            end else begin
               state_d = S_HIGH;
            end
         end
         S_QUAL_LOW: begin
            if (!en || din_sync) begin
               state_d = S_HIGH;
               qcnt_d  = '0;
            end else if (qcnt_q == QLAST) begin
               state_d = S_LOW;
               qcnt_d  = '0;
               fall_d  = 1'b1;
            end else begin
               qcnt_d  = qcnt_q + QW'(1);
            end
         end
         default: begin
            state_d = S_LOW;
            qcnt_d  = '0;
         end
      endcase

      level_d = (state_d == S_HIGH) || (state_d == S_QUAL_LOW);
      busy_d  = (state_d == S_QUAL_HIGH) || (state_d == S_QUAL_LOW);

      // Clear takes priority over a coincident rise
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (rise_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + EVT_CNT_WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and output registers
   always_ff @(posedge clkB or negedge rstN) begin
      if (!rstN) begin
         state_q <= S_LOW;
         qcnt_q  <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level      = level_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign busy       = busy_q;
   assign rise_count = cnt_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Scoreboard bench: three filter configurations share one stimulus stream and are
// checked against a sliding-window model of "last N samples all disagree with the level".
module tb_sync_debounce_edge;

   logic clkB = 1'b0;
   always #5 clkB = ~clkB;

   logic rstN, en, din_sync, clr_cnt;
   logic [2:0] lvl_s, ri_s, fa_s, bu_s;
   logic [7:0] c0_s;
   logic [1:0] c1_s;
   logic [2:0] c2_s;

   sync_debounce_edge #(.FILTER_CYCLES(4), .EVT_CNT_WIDTH(8)) u_d0 (
      .clkB(clkB), .rstN(rstN), .en(en), .din_sync(din_sync), .clr_cnt(clr_cnt),
      .level(lvl_s[0]), .rise(ri_s[0]), .fall(fa_s[0]), .busy(bu_s[0]), .rise_count(c0_s));
   sync_debounce_edge #(.FILTER_CYCLES(4), .EVT_CNT_WIDTH(2)) u_d1 (
      .clkB(clkB), .rstN(rstN), .en(en), .din_sync(din_sync), .clr_cnt(clr_cnt),
      .level(lvl_s[1]), .rise(ri_s[1]), .fall(fa_s[1]), .busy(bu_s[1]), .rise_count(c1_s));
   sync_debounce_edge #(.FILTER_CYCLES(1), .EVT_CNT_WIDTH(3)) u_d2 (
      .clkB(clkB), .rstN(rstN), .en(en), .din_sync(din_sync), .clr_cnt(clr_cnt),
      .level(lvl_s[2]), .rise(ri_s[2]), .fall(fa_s[2]), .busy(bu_s[2]), .rise_count(c2_s));

   localparam int FCV  [3] = '{4, 4, 1};
   localparam int CMAX [3] = '{255, 3, 7};

   typedef struct packed {
      logic [2:0]      lvl;
      logic [2:0]      ri;
      logic [2:0]      fa;
      logic [2:0]      bu;
      logic [2:0][7:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   logic       m_l   [3];
   logic [7:0] m_win [3];
   int         m_cnt [3];

   function automatic logic [7:0] act_cnt(input int d);
      case (d)
         0:       return c0_s;
         1:       return {6'd0, c1_s};
         default: return {5'd0, c2_s};
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_l[d]   = 1'b0;
         m_win[d] = 8'd0;
         m_cnt[d] = 0;
      end
   endtask

   // One clock of stimulus; the expected post-edge response goes into the scoreboard
   task automatic step(input logic e_i, input logic d_i, input logic c_i);
      exp_t       e;
      logic       q;
      logic [7:0] mask;
      @(negedge clkB);
      rstN = 1'b1; en = e_i; din_sync = d_i; clr_cnt = c_i;
      e = '0;
      for (int d = 0; d < 3; d++) begin
         q        = e_i && (d_i != m_l[d]);
         m_win[d] = {m_win[d][6:0], q};
         mask     = 8'((1 << FCV[d]) - 1);
         if ((m_win[d] & mask) == mask) begin
            m_l[d]   = ~m_l[d];
            e.ri[d]  = m_l[d];
            e.fa[d]  = ~m_l[d];
            m_win[d] = 8'd0;
         end else begin
            e.bu[d]  = q;
         end
         if (c_i) m_cnt[d] = 0;
         else if (e.ri[d] && m_cnt[d] < CMAX[d]) m_cnt[d] = m_cnt[d] + 1;
         e.lvl[d] = m_l[d];
         e.cnt[d] = 8'(m_cnt[d]);
      end
      exp_q.push_back(e);
   endtask

   task automatic run(input logic e_i, input logic d_i, input logic c_i, input int n);
      repeat (n) step(e_i, d_i, c_i);
   endtask

   // Reset asserted mid-cycle; outputs must clear before any clock edge
   task automatic reset_for(input int n);
      @(negedge clkB);
      rstN = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (lvl_s[d] !== 1'b0 || ri_s[d] !== 1'b0 || fa_s[d] !== 1'b0 ||
             bu_s[d] !== 1'b0 || act_cnt(d) !== 8'd0) begin
            fails++;
            $display("FAIL async_reset dut%0d: got lvl=%b rise=%b fall=%b busy=%b cnt=%0d, want all 0",
                     d, lvl_s[d], ri_s[d], fa_s[d], bu_s[d], act_cnt(d));
         end
      end
      model_reset();
      exp_q.push_back('0);
      repeat (n - 1) begin
         @(negedge clkB);
         exp_q.push_back('0);
      end
   endtask

   // Monitor: every rising edge the DUTs present a fresh output set
   initial begin
      forever begin
         @(posedge clkB);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int d = 0; d < 3; d++) begin
               tests++;
               if (lvl_s[d] !== mon_e.lvl[d] || ri_s[d] !== mon_e.ri[d] ||
                   fa_s[d] !== mon_e.fa[d] || bu_s[d] !== mon_e.bu[d] ||
                   act_cnt(d) !== mon_e.cnt[d]) begin
                  fails++;
                  $display("FAIL outputs dut%0d t=%0t: got lvl=%b rise=%b fall=%b busy=%b cnt=%0d, want lvl=%b rise=%b fall=%b busy=%b cnt=%0d",
                           d, $time, lvl_s[d], ri_s[d], fa_s[d], bu_s[d], act_cnt(d),
                           mon_e.lvl[d], mon_e.ri[d], mon_e.fa[d], mon_e.bu[d], mon_e.cnt[d]);
               end
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic
   initial begin
      logic rd;
      rstN = 1'b0; en = 1'b0; din_sync = 1'b0; clr_cnt = 1'b0;
      model_reset();
      repeat (3) @(posedge clkB);

      run(1'b1, 1'b0, 1'b0, 3);
      run(1'b1, 1'b1, 1'b0, 3);  run(1'b1, 1'b0, 1'b0, 6);    // glitch
      run(1'b1, 1'b1, 1'b0, 10); run(1'b1, 1'b0, 1'b0, 8);    // clean pulse
      run(1'b1, 1'b1, 1'b0, 2);  run(1'b0, 1'b1, 1'b0, 1);    // enable abort
      run(1'b1, 1'b1, 1'b0, 6);  run(1'b1, 1'b0, 1'b0, 6);
      repeat (5) begin                                          // saturation
         run(1'b1, 1'b1, 1'b0, 5); run(1'b1, 1'b0, 1'b0, 5);
      end
      run(1'b1, 1'b1, 1'b0, 3);  step(1'b1, 1'b1, 1'b1);      // clear on rise
      run(1'b1, 1'b1, 1'b0, 3);  run(1'b1, 1'b0, 1'b0, 6);
      run(1'b1, 1'b1, 1'b0, 2);  reset_for(3);                // reset mid-qualification
      run(1'b1, 1'b1, 1'b0, 6);  run(1'b1, 1'b0, 1'b0, 6);
      for (int i = 0; i < 12; i++) step(1'b1, 1'(i % 2), 1'b0);
      run(1'b1, 1'b0, 1'b0, 6);
      run(1'b1, 1'b1, 1'b0, 6);  run(1'b0, 1'b0, 1'b1, 5);    // en low while high
      run(1'b1, 1'b0, 1'b0, 6);

      rd = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 199) == 0) reset_for(2);
         if ($urandom_range(0, 3) == 0) rd = ~rd;
         step(1'($urandom_range(0, 9) != 0), rd, 1'($urandom_range(0, 29) == 0));
      end

      repeat (3) @(posedge clkB);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
